// File: rtl/shape_rasterizer_if.sv
// Command/write bundle between a painter (master) and shape_rasterizer (slave).
// A command is taken only when start is high while the rasterizer is idle; done pulses once per accepted command.
interface shape_rasterizer_if #(
  parameter int X_BITS     = 8,
  parameter int Y_BITS     = 7,
  parameter int COLOR_BITS = 3
);
  logic                  start;
  logic [1:0]            mode;
  logic [X_BITS-1:0]     x0;
  logic [Y_BITS-1:0]     y0;
  logic [X_BITS-1:0]     x1;
  logic [Y_BITS-1:0]     y1;
  logic [COLOR_BITS-1:0] color;
  logic                  busy;
  logic                  done;
  logic [X_BITS-1:0]     paint_x_co;
  logic [Y_BITS-1:0]     paint_y_co;
  logic [COLOR_BITS-1:0] color_out;
  logic                  print_enable;

  modport master (
    output start, mode, x0, y0, x1, y1, color,
    input  busy, done, paint_x_co, paint_y_co, color_out, print_enable
  );

  modport slave (
    input  start, mode, x0, y0, x1, y1, color,
    output busy, done, paint_x_co, paint_y_co, color_out, print_enable
  );
endinterface

// File: rtl/shape_rasterizer.sv
// Scans a latched bounding box in raster order and emits one held frame-buffer write per covered pixel.
// Outputs are registered from the next state, so each is visible during the state it belongs to.
module shape_rasterizer #(
  parameter int X_BITS     = 8,
  parameter int Y_BITS     = 7,
  parameter int COLOR_BITS = 3,
  parameter int WRITE_HOLD = 3
) (
  input  logic              Clck,
  input  logic              Reset,
  shape_rasterizer_if.slave sr,
  output logic [2:0]        o_state
);
  localparam int MAXB = (X_BITS > Y_BITS) ? X_BITS : Y_BITS;
  localparam int SQ_W = 2 * MAXB + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_TEST, S_LOAD, S_WRITE, S_GAP, S_NEXT
  } state_t;

  state_t r_state, w_state_n;

  logic [1:0]            r_mode;
  logic [X_BITS-1:0]     r_x0, r_x1, r_x1m, r_cx, r_x;
  logic [Y_BITS-1:0]     r_y0, r_y1, r_y1m, r_cy, r_r, r_y;
  logic [COLOR_BITS-1:0] r_color;
  logic [3:0]            r_hold;
  logic                  r_busy, r_done, r_pe;
  logic [X_BITS-1:0]     r_px;
  logic [Y_BITS-1:0]     r_py;
  logic [COLOR_BITS-1:0] r_pc;

  logic [X_BITS:0]   w_sum_x;
  logic [Y_BITS:0]   w_sum_y, w_span_y;
  logic              w_degen, w_last_x, w_last_y, w_on_edge, w_in_disc;
  logic              w_covered, w_done_n;
  logic [X_BITS-1:0] w_dx;
  logic [Y_BITS-1:0] w_dy;
  logic [SQ_W-1:0]   w_dx2, w_dy2, w_r2;

  assign w_sum_x  = {1'b0, r_x0} + {1'b0, r_x1};
  assign w_sum_y  = {1'b0, r_y0} + {1'b0, r_y1};
  assign w_span_y = {1'b0, r_y1} - {1'b0, r_y0};
  assign w_degen  = (r_x1 <= r_x0) || (r_y1 <= r_y0);
  assign w_last_x = (r_x == r_x1m);
  assign w_last_y = (r_y == r_y1m);

  // Full-width squares: the sum cannot overflow SQ_W bits for any coordinate pair.
  assign w_dx      = (r_x >= r_cx) ? (r_x - r_cx) : (r_cx - r_x);
  assign w_dy      = (r_y >= r_cy) ? (r_y - r_cy) : (r_cy - r_y);
  assign w_dx2     = SQ_W'(w_dx) * SQ_W'(w_dx);
  assign w_dy2     = SQ_W'(w_dy) * SQ_W'(w_dy);
  assign w_r2      = SQ_W'(r_r) * SQ_W'(r_r);
  assign w_in_disc = (w_dx2 + w_dy2) <= w_r2;
  assign w_on_edge = (r_x == r_x0) || w_last_x || (r_y == r_y0) || w_last_y;

  always_comb begin
    case (r_mode)
      2'd0:    w_covered = 1'b1;
      2'd1:    w_covered = w_on_edge;
      2'd2:    w_covered = w_in_disc;
      default: w_covered = (r_y == r_cy);
    endcase
  end

  always_ff @(posedge Clck) begin
    if (!Reset) r_state <= S_IDLE;
    else        r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    w_done_n  = 1'b0;
    unique case (r_state)
      S_IDLE:  if (sr.start) w_state_n = S_SETUP;
      S_SETUP: begin
        if (w_degen) begin
          w_state_n = S_IDLE;
          w_done_n  = 1'b1;
        end else begin
          w_state_n = S_TEST;
        end
      end
      S_TEST:  w_state_n = w_covered ? S_LOAD : S_NEXT;
      S_LOAD:  w_state_n = S_WRITE;
      S_WRITE: if (r_hold == 4'd0) w_state_n = S_GAP;
      S_GAP:   w_state_n = S_NEXT;
      S_NEXT: begin
        if (w_last_x && w_last_y) begin
          w_state_n = S_IDLE;
          w_done_n  = 1'b1;
        end else begin
          w_state_n = S_TEST;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge Clck) begin
    if (!Reset) begin
      r_mode <= '0; r_x0 <= '0; r_y0 <= '0; r_x1 <= '0; r_y1 <= '0; r_color <= '0;
      r_x1m <= '0; r_y1m <= '0; r_cx <= '0; r_cy <= '0; r_r <= '0;
      r_x <= '0; r_y <= '0; r_hold <= '0;
      r_busy <= 1'b0; r_done <= 1'b0; r_pe <= 1'b0;
      r_px <= '0; r_py <= '0; r_pc <= '0;
    end else begin
      r_busy <= (w_state_n != S_IDLE);
      r_done <= w_done_n;
      r_pe   <= (w_state_n == S_WRITE);
      case (r_state)
        S_IDLE: if (sr.start) begin
          r_mode <= sr.mode; r_color <= sr.color;
          r_x0 <= sr.x0; r_y0 <= sr.y0; r_x1 <= sr.x1; r_y1 <= sr.y1;
        end
        S_SETUP: begin
          r_cx  <= X_BITS'(w_sum_x >> 1);
          r_cy  <= Y_BITS'(w_sum_y >> 1);
          r_r   <= Y_BITS'(w_span_y >> 1);
          r_x1m <= r_x1 - X_BITS'(1);
          r_y1m <= r_y1 - Y_BITS'(1);
          r_x   <= r_x0;
          r_y   <= r_y0;
        end
        S_TEST: if (w_covered) begin
          r_px   <= r_x;
          r_py   <= r_y;
          r_pc   <= r_color;
          r_hold <= 4'(WRITE_HOLD - 1);
        end
        S_WRITE: if (r_hold != 4'd0) r_hold <= r_hold - 4'd1;
        S_NEXT: if (!(w_last_x && w_last_y)) begin
          if (w_last_x) begin
            r_x <= r_x0;
            r_y <= r_y + Y_BITS'(1);
          end else begin
            r_x <= r_x + X_BITS'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sr.busy         = r_busy;
  assign sr.done         = r_done;
  assign sr.print_enable = r_pe;
  assign sr.paint_x_co   = r_px;
  assign sr.paint_y_co   = r_py;
  assign sr.color_out    = r_pc;
  assign o_state         = r_state;
endmodule

// File: doc/shape_rasterizer.md
Name: shape_rasterizer

Overview:
- Parametrised pixel rasterizer that sits between the game-level painters and the VGA frame-buffer write port.
- Takes one shape command (bounding box, mode, colour) and streams one frame-buffer write per covered pixel in raster order, then signals completion.
- Replaces fixed-latency counter waits in callers with an explicit start/busy/done handshake.
- Supports filled rectangle, rectangle outline, filled disc and horizontal-centre line modes.

Parameters:
- X_BITS, 8, width of screen x coordinate.
- Y_BITS, 7, width of screen y coordinate.
- COLOR_BITS, 3, width of pixel colour.
- WRITE_HOLD, 3, cycles print_enable stays high per pixel (1..15).

Ports:
- Clck  in  1  clock, all state changes on rising edge.
- Reset  in  1  reset, synchronous, active-low.
- start  in  1  command strobe; sampled only in IDLE.
- mode  in  2  0 = filled rect, 1 = rect outline, 2 = filled disc, 3 = horizontal line through box centre row.
- x0  in  X_BITS  box left, inclusive.
- y0  in  Y_BITS  box top, inclusive.
- x1  in  X_BITS  box right, exclusive.
- y1  in  Y_BITS  box bottom, exclusive.
- color  in  COLOR_BITS  command colour.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the command has finished.
- paint_x_co  out  X_BITS  frame-buffer write x.
- paint_y_co  out  Y_BITS  frame-buffer write y.
- color_out  out  COLOR_BITS  frame-buffer write colour.
- print_enable  out  1  frame-buffer write enable.

Behaviour:
- Reset (Reset == 0 at a rising edge):
  - All outputs go to 0.
  - FSM goes to IDLE.
  - Applies immediately mid-command; no further writes and no done pulse for the aborted command.
- States: IDLE, SETUP, TEST, LOAD, WRITE, GAP, NEXT.
- IDLE:
  - start == 1 latches mode, box and colour, sets busy = 1, goes to SETUP.
  - Inputs are ignored in every other state; start while busy is dropped, not queued.
- SETUP:
  - Computes cx = (x0 + x1) >> 1, cy = (y0 + y1) >> 1, r = (y1 - y0) >> 1, using X_BITS+1 / Y_BITS+1 intermediates.
  - Degenerate box (x1 <= x0 or y1 <= y0): zero writes, done pulses the next cycle, busy drops with it.
  - Otherwise sets the scan position to (x0, y0) and goes to TEST.
- TEST: decides coverage of the current (x, y).
  - Mode 0: always covered.
  - Mode 1: covered iff x == x0, x == x1-1, y == y0 or y == y1-1.
  - Mode 2: covered iff (x-cx)^2 + (y-cy)^2 <= r^2. Differences are absolute values; squares and sum are held at 2*max(X_BITS,Y_BITS)+1 bits with no truncation.
  - Mode 3: covered iff y == cy.
  - Covered goes to LOAD; uncovered goes to NEXT, costing 1 cycle and no write.
- LOAD: drives paint_x_co, paint_y_co and color_out; print_enable stays 0.
- WRITE: print_enable = 1 for exactly WRITE_HOLD cycles, with coordinates and colour stable throughout.
- GAP: print_enable = 0 for 1 cycle.
- NEXT:
  - If x == x1-1 and y == y1-1: done = 1 for this one cycle, busy = 0, go to IDLE.
  - Else if x == x1-1: x = x0, y = y + 1, go to TEST.
  - Else: x = x + 1, go to TEST.
- Raster order is row-major, top-left first.
- Scan increments never wrap because the end test is an equality against the latched, exclusive bounds.
- paint_x_co, paint_y_co and color_out hold their last values after completion.
- Timing per command:
  - Each covered pixel costs 3 + WRITE_HOLD cycles (TEST, LOAD, WRITE, GAP); NEXT adds 1 more cycle.
  - First print_enable rises 4 cycles after the start edge.
  - Total = 2 + covered*(4 + WRITE_HOLD) + uncovered*2 cycles from start acceptance to done.
- done and start in the same cycle: done completes; start is accepted only when the FSM is in IDLE, i.e. on the following cycle.

Test Plan:
- Mode 0, box (4,5)-(6,7), colour 3'b110, WRITE_HOLD 3:
  - Exactly 4 writes at (4,5), (5,5), (4,6), (5,6).
  - Each write has print_enable high 3 cycles; color_out = 110.
  - done pulses once, 2+4*7 = 30 cycles after start.
- Mode 1, box (0,0)-(4,3):
  - 10 writes; (1,1) and (2,1) are never written.
  - done pulses once.
- Mode 2, box (0,0)-(5,5), so cx = 2, cy = 2, r = 2:
  - Exactly 13 writes.
  - (0,0), (4,4) and (1,0) are absent; (2,0) and (0,2) are present.
- Degenerate box (7,3)-(7,9):
  - No print_enable at any point.
  - done pulses 2 cycles after start; busy high for 1 cycle.
- start pulsed again during the 2nd write of a mode 0 command:
  - The second command is ignored and the write count is unchanged.
  - After done, a new start with mode 3, box (0,0)-(3,4) yields writes (0,2), (1,2), (2,2).
- Reset driven low while print_enable is high:
  - Next edge: all outputs 0, no done.
  - After Reset returns high, a new command executes normally.
